// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction-fetch stage ahead of the Harvard instruction ROM.
// Owns the PC and drives the ROM byte address. It captures the combinational
// ROM word into the instruction register, applies MIPS-style redirects with one
// delay slot, and halts on a redirect to HALT_ADDR or to a misaligned target.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous active-high reset
//   stall           downstream not ready; all fetch state holds
//   redirect        taken branch/jump for the instruction currently in ir
//   redirect_target byte address of the redirect destination
//   instr_address   ROM byte address (the pc register)
//   instr_readdata  combinational ROM data for instr_address
//   ir, ir_pc       fetched word and the address it came from
//   ir_valid        ir/ir_pc hold a live instruction
//   active          high until the CPU halts
//   fetch_error     sticky; halt was caused by a misaligned target
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  output logic        active,
  output logic        fetch_error
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_FETCH      = 2'd0,
    S_HALT_DRAIN = 2'd1,
    S_HALTED     = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic [XLEN-1:0]   ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              pend_valid_q, pend_valid_d;
  logic [XLEN-1:0]   pend_target_q, pend_target_d;
  logic              err_pend_q, err_pend_d;
  logic              active_q, active_d;
  logic              fetch_error_q, fetch_error_d;

  // Redirect selection: a live redirect beats a deferred one.
  logic              jump_c;
  logic [XLEN-1:0]   jump_tgt_c;
  logic              misalign_c;
  logic              halt_c;

  assign jump_c     = redirect | pend_valid_q;
  assign jump_tgt_c = redirect ? redirect_target : pend_target_q;
  assign misalign_c = (jump_tgt_c[1:0] != 2'b00);
  assign halt_c     = jump_c && ((jump_tgt_c == HALT_ADDR) || misalign_c);

  // Next-state and register-next logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    ir_pc_d       = ir_pc_q;
    ir_valid_d    = ir_valid_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    err_pend_d    = err_pend_q;
    active_d      = active_q;
    fetch_error_d = fetch_error_q;

    unique case (state_q)
      S_FETCH: begin
        if (stall) begin
          // Defer a redirect that arrives while stalled; newest wins.
          if (redirect) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redirect_target;
          end
        end else begin
          // pc already points at branch+4, so this edge captures the delay slot.
          ir_d         = instr_readdata;
          ir_pc_d      = pc_q;
          ir_valid_d   = 1'b1;
          pend_valid_d = 1'b0;
          if (halt_c) begin
            state_d    = S_HALT_DRAIN;
            err_pend_d = misalign_c;
          end else if (jump_c) begin
            pc_d = jump_tgt_c;
          end else begin
            pc_d = pc_q + XLEN'(4);
          end
        end
      end

      S_HALT_DRAIN: begin
        if (!stall) begin
          ir_valid_d    = 1'b0;
          active_d      = 1'b0;
          fetch_error_d = err_pend_q;
          state_d       = S_HALTED;
        end
      end

      S_HALTED: begin
      end

      default: begin
        state_d = S_HALTED;
      end
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_VECTOR;
      ir_q          <= '0;
      ir_pc_q       <= '0;
      ir_valid_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      err_pend_q    <= 1'b0;
      active_q      <= 1'b1;
      fetch_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ir_pc_q       <= ir_pc_d;
      ir_valid_q    <= ir_valid_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      err_pend_q    <= err_pend_d;
      active_q      <= active_d;
      fetch_error_q <= fetch_error_d;
    end
  end

  assign instr_address = pc_q;
  assign ir            = ir_q;
  assign ir_pc         = ir_pc_q;
  assign ir_valid      = ir_valid_q;
  assign active        = active_q;
  assign fetch_error   = fetch_error_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Instruction-fetch stage that sits directly upstream of the Harvard instruction ROM.
- Owns the program counter and drives the ROM byte address.
- Captures the ROM's combinational 32-bit read data into an instruction register for the decode stage.
- Implements MIPS-style redirects with one architectural delay slot, stalls from downstream, and the halt-on-jump-to-address-zero convention.

## Interface

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- HALT_ADDR, 32'h0000_0000, redirect target that terminates execution.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  downstream not ready; hold all fetch state.
- redirect  in  1  branch/jump taken for the instruction currently in `ir`.
- redirect_target  in  32  byte address of the redirect destination.
- instr_address  out  32  byte address to the instruction ROM; equals the `pc` register.
- instr_readdata  in  32  combinational ROM read data for `instr_address`.
- ir  out  32  fetched instruction word presented to decode.
- ir_pc  out  32  byte address the `ir` word was fetched from.
- ir_valid  out  1  `ir` and `ir_pc` hold a live instruction.
- active  out  1  high until the CPU halts.
- fetch_error  out  1  sticky; set when halt was caused by a misaligned target.

## Operation

- **State machine:** FETCH, HALT_DRAIN, HALTED.
- **Registers:**
  - `pc` (32)
  - `ir`, `ir_pc`, `ir_valid`
  - `pend_valid`, `pend_target` (32)
  - `err_pend`
  - `active`, `fetch_error`
- **Reset, when reset is high at an edge:**
  - `pc`=RESET_VECTOR, `ir`=0, `ir_pc`=0, `ir_valid`=0.
  - `pend_valid`=0, `pend_target`=0, `err_pend`=0.
  - `active`=1, `fetch_error`=0, state=FETCH.
  - Applies from any state, including HALTED or a pending stall.
- **FETCH, not stalled:**
  - `ir`<=`instr_readdata`, `ir_pc`<=`pc`, `ir_valid`<=1.
  - `pc`<= next PC, chosen by priority:
    1. `redirect`: `redirect_target`.
    2. `pend_valid`: `pend_target`.
    3. Otherwise: `pc`+4, modulo 2^32.
  - Clear `pend_valid` whenever it is consumed or overridden.
- **Delay slot:**
  - A redirect is signalled while the branch sits in `ir`.
  - At that moment `pc` already addresses branch+4.
  - The same edge therefore captures the delay-slot word, and the target is fetched next.
- **FETCH, stalled:**
  - `pc`, `ir`, `ir_pc`, `ir_valid` hold.
  - If `redirect` is high, `pend_valid`<=1 and `pend_target`<=`redirect_target`.
  - Newest redirect overwrites an older pending one.
- **Halt trigger:**
  - Condition: the selected redirect or pending target equals HALT_ADDR, or has bits [1:0]≠0.
  - The delay slot is still captured normally.
  - `pc` is not loaded with the target; it holds.
  - State becomes HALT_DRAIN.
  - `err_pend`<=1 if the cause was misalignment.
  - A misaligned target equal to HALT_ADDR is impossible because HALT_ADDR is aligned.
- **HALT_DRAIN:**
  - Not stalled: `ir_valid`<=0, `active`<=0, `fetch_error`<=`err_pend`, state=HALTED.
  - Stalled: hold everything.
  - `redirect` is ignored, since a branch in a delay slot is unsupported.
- **HALTED:**
  - All registers hold.
  - `stall` and `redirect` are ignored.
  - `instr_address` stays frozen.
  - Only reset exits.

## Timing

- `instr_address` is a pure register output, with no combinational path from any input.
- `ir`, `ir_pc`, `ir_valid`, `active` and `fetch_error` are all registered outputs.
- Latency is one cycle from `pc` to `ir`.
- First valid instruction:
  - Reset is low at edge E1.
  - `ir_valid`=1 after E1 with `ir_pc`=RESET_VECTOR.
  - `pc`=RESET_VECTOR+4 after E1.
- Throughput is one instruction per non-stalled cycle.
- `redirect` is sampled only at edges; a 1-cycle pulse suffices.
- Holding `redirect` asserted across a stall is idempotent.
- A stall asserted in the same cycle as `redirect` defers the redirect via the pending register. No target is lost.
- Halt:
  - Redirect-to-halt is sampled at edge N.
  - The delay slot is valid after N.
  - `ir_valid`=0 and `active`=0 after the first non-stalled edge following N.
- PC wrap: 32'hFFFF_FFFC + 4 gives 32'h0000_0000. This is not treated as a halt, because only redirects trigger halt.

## Test plan

- **Sequential fetch:**
  - Stimulus: ROM words at 0/4/8 = 32'h00200008 / 32'h00000000 / 32'h24020005; reset held 2 cycles, then released.
  - Required response:
    - During reset: `instr_address`=0, `ir_valid`=0, `active`=1.
    - After release, on successive edges: `ir_pc`=0, 4, 8 with `ir` equal to the matching word.
- **Redirect with delay slot:**
  - Stimulus: pulse `redirect`, target 32'h40, while `ir_pc`=8.
  - Required response: next `ir_pc` values are 32'hC, 32'h40, 32'h44.
- **Stall with redirect:**
  - Stimulus: with `ir_pc`=8, hold `stall` 3 cycles; pulse `redirect` (target 32'h40) only in stall cycle 2.
  - Required response:
    - `ir`, `ir_pc` and `instr_address`=32'hC stay held during the stall.
    - After release: `ir_pc`=32'hC, then 32'h40.
- **Halt:**
  - Stimulus: `redirect` to 32'h0 at `ir_pc`=32'h10.
  - Required response:
    - Next edge: `ir_pc`=32'h14, `ir_valid`=1.
    - Following edge: `ir_valid`=0, `active`=0, `fetch_error`=0, `instr_address` frozen.
    - Later `redirect` or `stall` has no effect.
- **Misaligned target:**
  - Stimulus: `redirect` to 32'h42 at `ir_pc`=8.
  - Required response: delay slot at 32'hC is valid; then `active`=0 and `fetch_error`=1.
- **Mid-operation reset:**
  - Stimulus: assert `reset` during HALTED, and separately during a stall holding a pending redirect.
  - Required response:
    - All outputs return to their reset values and `pend_valid` clears.
    - Fetch restarts at RESET_VECTOR; the old target is never fetched.
